// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the I/D memory arbiter:
//   - default address/data widths and timeout
//   - arbiter FSM state type
//   - requester port identifiers
//   - round-robin grant selection helper
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef logic port_t;

    localparam port_t PORT_I = 1'b0;
    localparam port_t PORT_D = 1'b1;

    // Single requester wins outright; on a tie the port that was not served
    // last gets the grant.
    function automatic port_t rr_pick(input logic  req_i_port,
                                      input logic  req_d_port,
                                      input port_t last_grant);
        port_t pick;
        if (req_i_port && req_d_port) begin
            pick = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (req_d_port) begin
            pick = PORT_D;
        end else begin
            pick = PORT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single-port memory between instruction fetch (port I, read-only)
// and load/store (port D, read/write). Round-robin arbitration, one memory
// transaction in flight, per-transaction timeout with error response.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   i_req/i_addr             fetch request (held until i_ack)
//   i_ack/i_rdata/i_err      one-cycle fetch response
//   d_req/d_we/d_addr/d_wdata data request (held until d_ack)
//   d_ack/d_rdata/d_err      one-cycle data response (rdata = 0 for writes)
//   mem_r_enable/mem_w_enable/mem_address/mem_word_in  memory command
//   mem_word_out/mem_rdy     memory read data and ready
//   busy                     high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              mem_r_enable,
    output logic              mem_w_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_word_in,
    input  logic [DATA_W-1:0] mem_word_out,
    input  logic              mem_rdy,

    output logic              busy
);

    // A zero timeout still needs a legal 1-bit counter; it is never compared.
    localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_e            state_q, state_d;
    port_t             port_q, port_d;
    port_t             last_q, last_d;
    logic              we_q, we_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              r_en_q, r_en_d;
    logic              w_en_q, w_en_d;

    logic              i_ack_q, i_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    port_t             grant;
    logic              grant_we;
    logic              timeout_hit;
    logic              resp_fire;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;

    // cnt_q holds the number of completed WAIT cycles without mem_rdy, so the
    // limit is hit while the TIMEOUT_CYC-th such cycle is in progress.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        last_d    = last_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        r_en_d    = r_en_q;
        w_en_d    = w_en_q;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;

        grant    = rr_pick(i_req, d_req, last_q);
        grant_we = (grant == PORT_D) && d_we;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    port_d  = grant;
                    we_d    = grant_we;
                    addr_d  = (grant == PORT_D) ? d_addr : i_addr;
                    wdata_d = grant_we ? d_wdata : '0;
                    r_en_d  = !grant_we;
                    w_en_d  = grant_we;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // mem_rdy is not looked at here: the memory has not yet seen
                // the enable.
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rdy) begin
                    r_en_d    = 1'b0;
                    w_en_d    = 1'b0;
                    resp_fire = 1'b1;
                    resp_data = we_q ? '0 : mem_word_out;
                    state_d   = ST_RESP;
                end else if (timeout_hit) begin
                    r_en_d    = 1'b0;
                    w_en_d    = 1'b0;
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = ST_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                last_d  = port_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response registers load on the WAIT->RESP edge so ack/rdata/err are
        // all valid during RESP and zero otherwise.
        i_ack_d   = resp_fire && (port_q == PORT_I);
        i_err_d   = i_ack_d && resp_err;
        i_rdata_d = i_ack_d ? resp_data : '0;
        d_ack_d   = resp_fire && (port_q == PORT_D);
        d_err_d   = d_ack_d && resp_err;
        d_rdata_d = d_ack_d ? resp_data : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_I;
            last_q    <= PORT_I;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            r_en_q    <= 1'b0;
            w_en_q    <= 1'b0;
            i_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            i_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            last_q    <= last_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            r_en_q    <= r_en_d;
            w_en_q    <= w_en_d;
            i_ack_q   <= i_ack_d;
            i_rdata_q <= i_rdata_d;
            i_err_q   <= i_err_d;
            d_ack_q   <= d_ack_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
        end
    end

    assign i_ack        = i_ack_q;
    assign i_rdata      = i_rdata_q;
    assign i_err        = i_err_q;
    assign d_ack        = d_ack_q;
    assign d_rdata      = d_rdata_q;
    assign d_err        = d_err_q;
    assign mem_r_enable = r_en_q;
    assign mem_w_enable = w_en_q;
    assign mem_address  = addr_q;
    assign mem_word_in  = wdata_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
